// File: rtl/cmp_mon_pkg.sv
// Shared definitions for the comparator alarm monitor: FSM state codes,
// default debounce thresholds and the run/clear counter width.
package cmp_mon_pkg;

    typedef enum logic [2:0] {
        NORMAL   = 3'd0,
        HI_PEND  = 3'd1,
        HI_ALARM = 3'd2,
        LO_PEND  = 3'd3,
        LO_ALARM = 3'd4
    } mon_state_e;

    localparam int unsigned DEF_TRIP_COUNT  = 3;
    localparam int unsigned DEF_CLEAR_COUNT = 2;

    // Wide enough for any threshold in 1..255.
    localparam int unsigned CNT_W = $clog2(256);

endpackage

// File: rtl/cmp_mon_sat_cnt.sv
// Generic saturating up-counter.
// Ports:
//   clk, rst  clock and asynchronous active-high reset
//   clr       restart the count; with inc also set, the count restarts at 1
//   inc       add one, holding at all-ones
//   cnt       current count
module cmp_mon_sat_cnt #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= W'(inc);
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/cmp_alarm_monitor.sv
// Debounced high/low alarm monitor for a comparator's eq/gt/lt outputs.
// A run of TRIP_COUNT consecutive gt (lt) samples raises the high (low)
// alarm; CLEAR_COUNT consecutive samples in any other direction drop it.
// Non-one-hot samples are discarded and counted.
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   in_valid         eq/gt/lt are sampled this cycle
//   eq, gt, lt       comparator result
//   clr_sticky       clears latched alarms (sticky build only)
//   hi_alarm/lo_alarm, hi_trip/lo_trip   alarm levels and raise pulses
//   err_onehot, err_cnt                  illegal-sample pulse and count
//   state            FSM state code for debug
// Build option: define CMP_MON_STICKY_EN to latch alarms until clr_sticky.
module cmp_alarm_monitor
    import cmp_mon_pkg::*;
#(
    parameter int unsigned TRIP_COUNT  = DEF_TRIP_COUNT,
    parameter int unsigned CLEAR_COUNT = DEF_CLEAR_COUNT,
    parameter int unsigned ERR_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             eq,
    input  logic             gt,
    input  logic             lt,
    input  logic             clr_sticky,
    output logic             hi_alarm,
    output logic             lo_alarm,
    output logic             hi_trip,
    output logic             lo_trip,
    output logic             err_onehot,
    output logic [ERR_W-1:0] err_cnt,
    output logic [2:0]       state
);

    localparam bit TRIP_ONE = (TRIP_COUNT == 1);

    mon_state_e       state_q, state_d;
    logic [CNT_W-1:0] run_cnt, clr_cnt;
    logic             run_clr, run_inc, cl_clr, cl_inc;
    logic             legal, acc, run_hit, clr_hit;
    logic             hi_set, lo_set;

    assign legal   = ({eq, gt, lt} == 3'b100) || ({eq, gt, lt} == 3'b010) ||
                     ({eq, gt, lt} == 3'b001);
    assign acc     = in_valid && legal;
    // Thresholds are compared against the count this sample would produce.
    assign run_hit = ((9'(run_cnt) + 9'd1) == 9'(TRIP_COUNT));
    assign clr_hit = ((9'(clr_cnt) + 9'd1) == 9'(CLEAR_COUNT));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= NORMAL;
        else     state_q <= state_d;
    end

    // Next-state and counter control.
    always_comb begin
        state_d = state_q;
        run_clr = 1'b0;
        run_inc = 1'b0;
        cl_clr  = 1'b0;
        cl_inc  = 1'b0;
        case (state_q)
            NORMAL: begin
                if (acc && gt) begin
                    run_clr = 1'b1;
                    run_inc = 1'b1;
                    state_d = TRIP_ONE ? HI_ALARM : HI_PEND;
                end else if (acc && lt) begin
                    run_clr = 1'b1;
                    run_inc = 1'b1;
                    state_d = TRIP_ONE ? LO_ALARM : LO_PEND;
                end
            end
            HI_PEND, LO_PEND: begin
                if (acc) begin
                    if (eq) begin
                        run_clr = 1'b1;
                        state_d = NORMAL;
                    end else if ((state_q == HI_PEND) == gt) begin
                        run_inc = 1'b1;
                        if (run_hit) state_d = gt ? HI_ALARM : LO_ALARM;
                    end else begin
                        // Direction reversal starts a fresh run on the other side.
                        run_clr = 1'b1;
                        run_inc = 1'b1;
                        if (gt) state_d = TRIP_ONE ? HI_ALARM : HI_PEND;
                        else    state_d = TRIP_ONE ? LO_ALARM : LO_PEND;
                    end
                end
            end
            HI_ALARM, LO_ALARM: begin
                if (acc) begin
                    if ((state_q == HI_ALARM) ? gt : lt) begin
                        cl_clr = 1'b1;
                    end else if (clr_hit) begin
                        // Exit always lands in NORMAL, never in the opposite pending state.
                        cl_clr  = 1'b1;
                        run_clr = 1'b1;
                        state_d = NORMAL;
                    end else begin
                        cl_inc = 1'b1;
                    end
                end
            end
            default: begin
                run_clr = 1'b1;
                cl_clr  = 1'b1;
                state_d = NORMAL;
            end
        endcase
    end

    cmp_mon_sat_cnt #(.W(CNT_W)) u_run (
        .clk(clk), .rst(rst), .clr(run_clr), .inc(run_inc), .cnt(run_cnt)
    );

    cmp_mon_sat_cnt #(.W(CNT_W)) u_clr (
        .clk(clk), .rst(rst), .clr(cl_clr), .inc(cl_inc), .cnt(clr_cnt)
    );

    cmp_mon_sat_cnt #(.W(ERR_W)) u_err (
        .clk(clk), .rst(rst), .clr(1'b0), .inc(in_valid && !legal), .cnt(err_cnt)
    );

    assign hi_set = (state_d == HI_ALARM) && (state_q != HI_ALARM);
    assign lo_set = (state_d == LO_ALARM) && (state_q != LO_ALARM);
    assign state  = state_q;

    // Registered pulses and alarm levels.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_trip    <= 1'b0;
            lo_trip    <= 1'b0;
            err_onehot <= 1'b0;
            hi_alarm   <= 1'b0;
            lo_alarm   <= 1'b0;
        end else begin
            hi_trip    <= hi_set;
            lo_trip    <= lo_set;
            err_onehot <= in_valid && !legal;
`ifdef CMP_MON_STICKY_EN
            // A new trip takes priority over a coincident clear.
            if (hi_set)          hi_alarm <= 1'b1;
            else if (clr_sticky) hi_alarm <= 1'b0;
            if (lo_set)          lo_alarm <= 1'b1;
            else if (clr_sticky) lo_alarm <= 1'b0;
`else
            hi_alarm   <= (state_d == HI_ALARM);
            lo_alarm   <= (state_d == LO_ALARM);
`endif
        end
    end

`ifndef CMP_MON_STICKY_EN
    logic clr_sticky_unused;
    assign clr_sticky_unused = clr_sticky;
`endif

endmodule

// File: doc/cmp_alarm_monitor.md
Name: cmp_alarm_monitor

Overview:
- Downstream consumer of the 4-bit comparator's eq/gt/lt outputs.
- Accepts one qualified compare result per valid cycle.
- Debounces runs of gt or lt into registered high/low alarms, with trip and clear hysteresis.
- Flags illegal, non-one-hot result encodings and keeps a saturating count of them.

Parameters:
TRIP_COUNT, 3, consecutive same-direction samples needed to raise an alarm (legal range 1..255)
CLEAR_COUNT, 2, consecutive non-alarm-direction samples needed to drop an alarm (legal range 1..255)
ERR_W, 8, width of the saturating error counter

Ports:
clk  in  1  single clock; all state updates on the rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  eq/gt/lt are sampled this cycle
eq  in  1  comparator a==b
gt  in  1  comparator a>b
lt  in  1  comparator a<b
clr_sticky  in  1  clears latched alarms (used only with the optional feature)
hi_alarm  out  1  high alarm active
lo_alarm  out  1  low alarm active
hi_trip  out  1  one-cycle pulse when the high alarm is raised
lo_trip  out  1  one-cycle pulse when the low alarm is raised
err_onehot  out  1  one-cycle pulse when an illegal sample is seen
err_cnt  out  ERR_W  count of illegal samples, saturating
state  out  3  FSM state code, for debug

Behaviour:
- **Reset:** rst is asynchronous. When asserted, all outputs go to 0, state goes to NORMAL, and the run and clear counters go to 0. This holds even mid-run or mid-alarm; no pending trip survives.
- **Sample acceptance:**
  - A sample is accepted on a rising edge with in_valid=1.
  - With in_valid=0, state and counters hold and all pulse outputs are 0.
- **Illegal samples:**
  - An accepted sample is legal only if exactly one of eq/gt/lt is 1.
  - Illegal samples are discarded: state and counters are unchanged, err_onehot pulses next cycle, and err_cnt increments, saturating at all-ones.
- **State encoding:** NORMAL=0, HI_PEND=1, HI_ALARM=2, LO_PEND=3, LO_ALARM=4.
- **Transitions** (legal samples only; run = consecutive-sample counter):
  - NORMAL:
    - gt: run=1, go to HI_PEND, or straight to HI_ALARM if TRIP_COUNT==1.
    - lt: symmetric, to LO_PEND or LO_ALARM.
    - eq: stay.
  - HI_PEND:
    - gt: run++. When run reaches TRIP_COUNT, go to HI_ALARM.
    - lt: run=1, go to LO_PEND (or LO_ALARM if TRIP_COUNT==1).
    - eq: run=0, go to NORMAL.
  - LO_PEND: mirror of HI_PEND.
  - HI_ALARM:
    - eq or lt: clr++. When clr reaches CLEAR_COUNT, go to NORMAL with clr=0 and run=0. The exit always goes to NORMAL, even if the last sample was lt.
    - gt: clr=0.
  - LO_ALARM: mirror of HI_ALARM.
- **Output timing:**
  - All outputs are registered.
  - hi_alarm = (state==HI_ALARM), and is visible in the cycle after the edge that accepts the TRIP_COUNT-th consecutive gt.
  - hi_trip pulses in that same cycle; lo_trip likewise for the low side.
- **Counter widths:** run and clr counters are $clog2(256) bits and never exceed their parameter value.
- hi_alarm and lo_alarm are never both 1 without the optional feature.
- **Unused encodings:** state codes 5..7 are unreachable; if entered, the FSM recovers to NORMAL on the next edge.

Optional Feature:
- Macro: CMP_MON_STICKY_EN
- **Defined:**
  - hi_alarm and lo_alarm latch at 1 once raised and stay set after the FSM leaves the alarm state.
  - A clr_sticky=1 edge clears them.
  - If a trip and clr_sticky occur on the same edge, set wins.
  - With latching, both alarms may be 1 together.
- **Undefined:** alarms follow the FSM state and clr_sticky is ignored.

Decomposition:
- Package cmp_mon_pkg:
  - state enum and codes
  - default TRIP_COUNT/CLEAR_COUNT constants
  - counter width constant
- Sub-module cmp_mon_sat_cnt: generic saturating counter with increment, clear and width parameter. It is instantiated for run, clr and err_cnt.

Test Plan (TRIP_COUNT=3, CLEAR_COUNT=2):
1. **Trip high:** gt,gt,gt valid on consecutive cycles -> hi_alarm=1 and hi_trip pulse after the 3rd edge; state=2.
2. **Broken run:** gt,gt,eq,gt,gt -> no alarm; state=1 with run=2 at the end.
3. **Clear with hysteresis:** from HI_ALARM, lt,gt,lt,eq -> alarm holds through lt,gt,lt and drops after eq (second consecutive clear); state=0, not LO_PEND.
4. **Illegal samples:** in_valid with {eq,gt,lt}=3'b011, then 3'b000, then 3'b111 -> three err_onehot pulses, err_cnt=3, state unchanged. With ERR_W=2, five illegal samples -> err_cnt=3.
5. **Reset mid-alarm:** rst asserted asynchronously mid-cycle while in LO_ALARM -> all outputs 0 immediately. After release, lt,lt,lt is needed to re-trip.
6. **Sticky build (CMP_MON_STICKY_EN):**
   - Trip high, then clear to NORMAL -> hi_alarm stays 1.
   - Trip low -> lo_alarm=1 as well.
   - clr_sticky coincident with a new hi trip -> hi_alarm stays 1.
   - clr_sticky alone -> both alarms return to 0.
